// File: rtl/mem_pkg.sv
// Shared memory-interface constants and word/address types for the memory
// responder and the cache fill controllers that talk to it.
package mem_pkg;
    localparam int MEM_DATA_W      = 16;
    localparam int MEM_ADDR_W      = 16;
    localparam int MEM_LAT_DEFAULT = 4;
    localparam int BLOCK_WORDS     = 8;

    typedef logic [MEM_DATA_W-1:0] mem_word_t;
    typedef logic [MEM_ADDR_W-1:0] mem_addr_t;
endpackage

// File: rtl/mem_req_pipe.sv
// Read-response delay line: LATENCY-deep valid+data shift register, async active-low clear.
// Latency: LATENCY cycles input to out_*; no backpressure, one entry accepted every cycle.
module mem_req_pipe #(
    parameter int LATENCY = 4,
    parameter int DATA_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_vld,
    input  logic [DATA_W-1:0] in_dat,
    output logic              out_vld,
    output logic [DATA_W-1:0] out_dat
);
    logic [LATENCY-1:0]             vld_q, vld_d;
    logic [LATENCY-1:0][DATA_W-1:0] dat_q, dat_d;
    logic [LATENCY:0]               vld_ext;
    logic [LATENCY:0][DATA_W-1:0]   dat_ext;

    // Element 0 of the extended vectors is the incoming entry, the top one the leaving entry.
    always_comb begin
        vld_ext = {vld_q, in_vld};
        dat_ext = {dat_q, in_dat};
        vld_d   = vld_ext[LATENCY-1:0];
        dat_d   = dat_ext[LATENCY-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            dat_q <= '0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

    assign out_vld = vld_ext[LATENCY];
    assign out_dat = dat_ext[LATENCY];
endmodule

// File: rtl/mem_responder.sv
// Main-memory responder: word reads return LATENCY+0 cycles after issue, writes commit in one cycle.
// Latency: read data valid in the cycle after edge N+LATENCY; no backpressure, one read per cycle.
// MEM_ALIGN_CHK_EN enables the sticky misaligned-access flag mem_err.
module mem_responder
    import mem_pkg::*;
#(
    parameter int LATENCY = MEM_LAT_DEFAULT,
    parameter int DEPTH_W = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [MEM_ADDR_W-1:0] mem_addr,
    input  logic [MEM_DATA_W-1:0] mem_write_data,
    output logic                  mem_data_valid,
    output logic [MEM_DATA_W-1:0] mem_read_data,
    output logic                  mem_busy,
    output logic                  mem_err
);
    localparam int CNT_W = $clog2(LATENCY + 1);

    mem_word_t          mem_q [2**DEPTH_W];
    logic [DEPTH_W-1:0] word_idx;
    mem_word_t          rd_word;
    logic               pipe_vld;
    mem_word_t          pipe_dat;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               dv_q, dv_d;
    mem_word_t          rdata_q, rdata_d;
    logic               err_q, err_d;
    logic               addr_unused;

    assign word_idx    = mem_addr[DEPTH_W:1];
    assign addr_unused = ^mem_addr;

    // Read and write share mem_addr, so a same-cycle write always hits the read word.
    assign rd_word = mem_write ? mem_write_data : mem_q[word_idx];

    // Array is never cleared; reset only blocks writes while asserted.
    always_ff @(posedge clk or negedge rst) begin
        if (rst && mem_write) begin
            mem_q[word_idx] <= mem_write_data;
        end
    end

    mem_req_pipe #(
        .LATENCY (LATENCY),
        .DATA_W  (MEM_DATA_W)
    ) u_pipe (
        .clk     (clk),
        .rst_n   (rst),
        .in_vld  (mem_read),
        .in_dat  (rd_word),
        .out_vld (pipe_vld),
        .out_dat (pipe_dat)
    );

    always_comb begin
        cnt_d = cnt_q;
        if (mem_read && !pipe_vld) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!mem_read && pipe_vld) begin
            cnt_d = cnt_q - 1'b1;
        end
        dv_d    = pipe_vld;
        rdata_d = pipe_vld ? pipe_dat : rdata_q;
`ifdef MEM_ALIGN_CHK_EN
        err_d   = err_q | ((mem_read | mem_write) & mem_addr[0]);
`else
        err_d   = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            dv_q    <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            dv_q    <= dv_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign mem_data_valid = dv_q;
    assign mem_read_data  = rdata_q;
    assign mem_busy       = (cnt_q != '0);
    assign mem_err        = err_q;
endmodule

// File: tb/tb_mem_responder.sv
// Directed + random bench for mem_responder against a queue-based response model.
module tb_mem_responder;
    import mem_pkg::*;

    localparam int LAT = MEM_LAT_DEFAULT;

    typedef struct {
        int          due;
        logic [15:0] dat;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [15:0] mem_addr = '0;
    logic [15:0] mem_write_data = '0;
    logic        mem_data_valid;
    logic [15:0] mem_read_data;
    logic        mem_busy;
    logic        mem_err;

    int          n_vec = 0;
    int          n_err = 0;
    int          edge_n = 0;
    resp_t       pend[$];
    logic [15:0] model_mem [int];
    logic [15:0] exp_rdata = '0;
    logic        exp_err = 1'b0;
    logic [15:0] pool [16];

    mem_responder #(.LATENCY(LAT), .DEPTH_W(15)) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_data_valid (mem_data_valid),
        .mem_read_data  (mem_read_data),
        .mem_busy       (mem_busy),
        .mem_err        (mem_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired at edge %0d", edge_n);
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h edge=%0d", tag, obs, exp, edge_n);
        end
    endtask

    function automatic logic [15:0] model_rd(input logic [15:0] addr);
        int idx = int'(addr[15:1]);
        return model_mem.exists(idx) ? model_mem[idx] : 16'hxxxx;
    endfunction

    task automatic check_outputs();
        logic exp_vld = 1'b0;
        if (pend.size() > 0 && pend[0].due == edge_n) begin
            exp_vld   = 1'b1;
            exp_rdata = pend[0].dat;
            void'(pend.pop_front());
        end
        chk("valid", 16'(mem_data_valid), 16'(exp_vld));
        chk("rdata", mem_read_data, exp_rdata);
        chk("busy", 16'(mem_busy), 16'(pend.size() != 0));
        chk("err", 16'(mem_err), 16'(exp_err));
    endtask

    // Drive one cycle of stimulus, update the model at the edge, check 1ns later.
    task automatic step(input logic rd, input logic wr, input logic [15:0] addr, input logic [15:0] wd);
        logic [15:0] rdat;
        resp_t       r;
        mem_read = rd; mem_write = wr; mem_addr = addr; mem_write_data = wd;
        @(posedge clk);
        edge_n++;
        if (rst) begin
`ifdef MEM_ALIGN_CHK_EN
            if (addr[0] && (rd || wr)) exp_err = 1'b1;
`endif
            rdat = wr ? wd : model_rd(addr);
            if (wr) model_mem[int'(addr[15:1])] = wd;
            if (rd) begin
                r.due = edge_n + LAT;
                r.dat = rdat;
                pend.push_back(r);
            end
        end
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0000, 16'h0000);
    endtask

    task automatic reset_now();
        rst = 1'b0;
        #1;
        pend.delete();
        exp_rdata = '0;
        exp_err   = 1'b0;
        chk("rst_valid", 16'(mem_data_valid), 16'h0000);
        chk("rst_busy", 16'(mem_busy), 16'h0000);
        chk("rst_rdata", mem_read_data, 16'h0000);
        chk("rst_err", 16'(mem_err), 16'h0000);
    endtask

    initial begin
        #1;
        reset_now();
        idle(2);
        rst = 1'b1;
        idle(1);

        // Single read of a preloaded word.
        step(1'b0, 1'b1, 16'h0010, 16'hBEEF);
        idle(2);
        step(1'b1, 1'b0, 16'h0010, 16'h0000);
        idle(LAT + 2);

        // Block fill: back-to-back reads in address order.
        for (int i = 0; i < BLOCK_WORDS; i++) step(1'b0, 1'b1, 16'(16'h0100 + 2 * i), 16'(16'hC000 + i));
        for (int i = 0; i < BLOCK_WORDS; i++) step(1'b1, 1'b0, 16'(16'h0100 + 2 * i), 16'h0000);
        idle(LAT + 2);

        // Same-cycle write and read forwards the new data.
        step(1'b0, 1'b1, 16'h0200, 16'h0F0F);
        step(1'b1, 1'b1, 16'h0200, 16'h1234);
        idle(LAT + 2);

        // Read data is captured at issue; a later write does not change it.
        step(1'b0, 1'b1, 16'h0300, 16'hAAAA);
        step(1'b1, 1'b0, 16'h0300, 16'h0000);
        step(1'b0, 1'b1, 16'h0300, 16'h5555);
        idle(LAT + 1);
        step(1'b1, 1'b0, 16'h0300, 16'h0000);
        idle(LAT + 2);

        // Reset two cycles into a burst; writes under reset must not land.
        for (int i = 0; i < BLOCK_WORDS; i++) step(1'b0, 1'b1, 16'(16'h0400 + 2 * i), 16'(16'h7700 + i));
        step(1'b1, 1'b0, 16'h0400, 16'h0000);
        step(1'b1, 1'b0, 16'h0402, 16'h0000);
        reset_now();
        step(1'b1, 1'b1, 16'h0404, 16'hDEAD);
        step(1'b1, 1'b1, 16'h0406, 16'hDEAD);
        rst = 1'b1;
        idle(LAT + 2);
        for (int i = 0; i < BLOCK_WORDS; i++) step(1'b1, 1'b0, 16'(16'h0400 + 2 * i), 16'h0000);
        idle(LAT + 2);

        // Odd byte address reads the containing word; error flag only with the check enabled.
        step(1'b1, 1'b0, 16'h0011, 16'h0000);
        idle(LAT + 2);

        // Random mix of reads and writes over a preloaded pool.
        for (int i = 0; i < 16; i++) begin
            pool[i] = 16'(16'h0800 + 2 * i);
            step(1'b0, 1'b1, pool[i], 16'($urandom));
        end
        for (int i = 0; i < 300; i++) begin
            logic [15:0] a;
            a = pool[$urandom_range(0, 15)];
            if ($urandom_range(0, 15) == 0) a[0] = 1'b1;
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0), a, 16'($urandom));
        end
        idle(LAT + 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
